// File: rtl/store_queue_ctrl.sv
// Store buffer and in-order write sequencer between the memory stage and the
// data memory / MMIO write port. It decodes each store into a byte mask and
// lane-aligned data, queues it, drains the queue over a valid/ready handshake,
// flags loads that hit a queued word, and runs a fence drain sequence.
module store_queue_ctrl #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st_valid,
    input  logic [1:0]       st_sel,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    output logic             st_ready,
    output logic             misalign_err,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wmask,
    input  logic             ld_valid,
    input  logic [31:0]      ld_addr,
    output logic             ld_hazard,
    input  logic             drain_req,
    output logic             drain_done,
    output logic [PTR_W:0]   q_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    // One queued store: word address, lane-aligned data and byte enables.
    typedef struct packed {
        logic [29:0] word;
        logic [31:0] data;
        logic [3:0]  mask;
    } entry_t;

    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = (PTR_W)'(1);

    entry_t           entry_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             misalign_q, misalign_d;
    state_e           state_q;
    logic             drain_done_q;

    entry_t           new_entry;
    logic             aligned;
    logic             store_req;
    logic             push;
    logic             pop;
    logic             word_hit;
    logic             unused_ld_bits;

    // Low load-address bits do not matter: hazards are tracked per word.
    assign unused_ld_bits = ^ld_addr[1:0];

    assign st_ready      = (state_q == RUN) && (count_q < DEPTH_C);
    assign mem_req_valid = (count_q != '0);
    assign q_count       = count_q;
    assign misalign_err  = misalign_q;
    assign drain_done    = drain_done_q;

    // Head entry drives the memory port; zero when the queue is empty so the
    // port is quiet after reset even though entry storage is not cleared.
    assign mem_addr  = mem_req_valid ? {entry_q[head_q].word, 2'b00} : 32'h0;
    assign mem_wdata = mem_req_valid ? entry_q[head_q].data : 32'h0;
    assign mem_wmask = mem_req_valid ? entry_q[head_q].mask : 4'h0;

    // Decode the incoming store into mask, replicated lane data and alignment.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        new_entry.word = st_addr[31:2];
        new_entry.data = st_data;
        new_entry.mask = 4'b0000;
        aligned        = 1'b1;
        case (st_sel)
            2'b00: begin
                new_entry.mask = 4'b0001 << st_addr[1:0];
                new_entry.data = {4{st_data[7:0]}};
            end
            2'b01: begin
                new_entry.mask = st_addr[1] ? 4'b1100 : 4'b0011;
                new_entry.data = {2{st_data[15:0]}};
                aligned        = ~st_addr[0];
            end
            2'b10: begin
                new_entry.mask = 4'b1111;
                aligned        = (st_addr[1:0] == 2'b00);
            end
            default: begin
                new_entry.mask = 4'b0000;
            end
        endcase
    end

    assign store_req  = st_valid && st_ready && (st_sel != 2'b11);
    assign push       = store_req && aligned;
    assign misalign_d = store_req && !aligned;
    assign pop        = mem_req_valid && mem_req_ready;

    // Compare the load word against every valid entry, including one leaving now.
    always_comb begin
        word_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (entry_q[i].word == ld_addr[31:2])) begin
                word_hit = 1'b1;
            end
        end
    end

    assign ld_hazard = ld_valid && word_hit;

    // Next-state pointers, occupancy and valid bits for enqueue/dequeue.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_ONE;
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Entry payload storage, written at the tail on enqueue.
    always_ff @(posedge clk) begin
        // NOTE: payload storage is deliberately not reset; valid_q and count_q alone decide what is live.
        if (push) begin
            entry_q[tail_q] <= new_entry;
        end
    end

    // Queue control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
        if (!rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    // Drain sequencer: RUN -> DRAIN on request, DONE once empty, one-cycle done pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= RUN;
            drain_done_q <= 1'b0;
        end else begin
            drain_done_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (drain_req) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (count_q == '0) begin
                        state_q      <= DONE;
                        drain_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_queue_ctrl.sv
// Self-checking bench for store_queue_ctrl: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a queue-based model.
module tb_store_queue_ctrl;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             st_valid;
    logic [1:0]       st_sel;
    logic [31:0]      st_addr;
    logic [31:0]      st_data;
    logic             st_ready;
    logic             misalign_err;
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_wmask;
    logic             ld_valid;
    logic [31:0]      ld_addr;
    logic             ld_hazard;
    logic             drain_req;
    logic             drain_done;
    logic [PTR_W:0]   q_count;

    store_queue_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .st_valid      (st_valid),
        .st_sel        (st_sel),
        .st_addr       (st_addr),
        .st_data       (st_data),
        .st_ready      (st_ready),
        .misalign_err  (misalign_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .ld_valid      (ld_valid),
        .ld_addr       (ld_addr),
        .ld_hazard     (ld_hazard),
        .drain_req     (drain_req),
        .drain_done    (drain_done),
        .q_count       (q_count)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue of pending writes plus a drain phase.
    typedef struct {
        logic [29:0] word;
        logic [31:0] data;
        logic [3:0]  mask;
    } ent_t;

    ent_t mq[$];
    int   mode;          // 0 accepting, 1 draining, 2 drain just finished
    bit   exp_mis;
    bit   last_accept;
    int   n_checks = 0;
    int   n_errors = 0;
    int   done_pulses;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic ent_t make_entry(input logic [1:0] sel, input logic [31:0] a,
                                        input logic [31:0] d);
        ent_t e;
        e.word = a[31:2];
        case (sel)
            2'b00: begin
                e.mask = 4'(1 << (a % 4));
                e.data = {24'h0, d[7:0]} * 32'h01010101;
            end
            2'b01: begin
                e.mask = ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
                e.data = {16'h0, d[15:0]} * 32'h00010001;
            end
            default: begin
                e.mask = 4'b1111;
                e.data = d;
            end
        endcase
        return e;
    endfunction

    function automatic bit is_aligned(input logic [1:0] sel, input logic [31:0] a);
        if (sel == 2'b01) return (a % 2) == 0;
        if (sel == 2'b10) return (a % 4) == 0;
        return 1'b1;
    endfunction

    // One clock: compare all outputs mid-cycle, advance the model, step past the edge.
    task automatic cycle();
        int          sz;
        bit          e_ready, e_haz, e_valid, req, take, pop;
        logic [31:0] e_addr, e_data;
        logic [3:0]  e_mask;
        @(negedge clk);
        sz      = mq.size();
        e_ready = (mode == 0) && (sz < DEPTH);
        e_valid = (sz != 0);
        e_haz   = 1'b0;
        if (ld_valid) begin
            foreach (mq[i]) if (mq[i].word == ld_addr[31:2]) e_haz = 1'b1;
        end
        e_addr = e_valid ? {mq[0].word, 2'b00} : 32'h0;
        e_data = e_valid ? mq[0].data : 32'h0;
        e_mask = e_valid ? mq[0].mask : 4'h0;
        check("st_ready", st_ready, e_ready);
        check("mem_req_valid", mem_req_valid, e_valid);
        check("mem_addr", mem_addr, e_addr);
        check("mem_wdata", mem_wdata, e_data);
        check("mem_wmask", mem_wmask, e_mask);
        check("q_count", q_count, sz);
        check("ld_hazard", ld_hazard, e_haz);
        check("misalign_err", misalign_err, exp_mis);
        check("drain_done", drain_done, mode == 2);
        if (drain_done === 1'b1) done_pulses++;
        if (!rst) begin
            mq.delete();
            mode        = 0;
            exp_mis     = 1'b0;
            last_accept = 1'b0;
        end else begin
            req     = st_valid && e_ready && (st_sel != 2'b11);
            take    = req && is_aligned(st_sel, st_addr);
            exp_mis = req && !is_aligned(st_sel, st_addr);
            pop     = e_valid && mem_req_ready;
            case (mode)
                0:       if (drain_req) mode = 1;
                1:       if (sz == 0) mode = 2;
                default: mode = 0;
            endcase
            if (pop) void'(mq.pop_front());
            if (take) mq.push_back(make_entry(st_sel, st_addr, st_data));
            last_accept = take;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        st_valid  = 1'b0;
        st_sel    = 2'b11;
        st_addr   = 32'h0;
        st_data   = 32'h0;
        ld_valid  = 1'b0;
        ld_addr   = 32'h0;
        drain_req = 1'b0;
    endtask

    task automatic put_store(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_sel   = sel;
        st_addr  = a;
        st_data  = d;
    endtask

    initial begin
        int k;
        idle_inputs();
        mem_req_ready = 1'b0;
        rst           = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mq.delete();
        mode        = 0;
        exp_mis     = 1'b0;
        done_pulses = 0;
        rst         = 1'b1;

        // Reset state.
        cycle();

        // 1: byte store at 0x1003 goes straight through.
        mem_req_ready = 1'b1;
        put_store(2'b00, 32'h0000_1003, 32'h0000_00AB);
        cycle();
        idle_inputs();
        #1;
        check("t1_valid", mem_req_valid, 1'b1);
        check("t1_addr", mem_addr, 32'h0000_1000);
        check("t1_mask", mem_wmask, 4'b1000);
        check("t1_wdata", mem_wdata, 32'hABAB_ABAB);
        cycle();
        check("t1_empty", q_count, 0);

        // 2: halfword upper lane, then a dropped misaligned word.
        mem_req_ready = 1'b0;
        put_store(2'b01, 32'h0000_2002, 32'h1234_CAFE);
        cycle();
        check("t2_mask", mem_wmask, 4'b1100);
        check("t2_wdata", mem_wdata, 32'hCAFE_CAFE);
        put_store(2'b10, 32'h0000_2005, 32'hDEAD_BEEF);
        cycle();
        check("t2_mis", misalign_err, 1'b1);
        check("t2_cnt", q_count, 1);
        idle_inputs();
        cycle();
        check("t2_mis_pulse", misalign_err, 1'b0);
        mem_req_ready = 1'b1;
        cycle();

        // 3: fill the queue while memory stalls; the fifth store waits.
        k = 0;
        for (int c = 0; c < 16; c++) begin
            mem_req_ready = (c >= 7);
            if (k < 5) put_store(2'b10, 32'h0000_4000 + 32'(k * 4), 32'h0000_0100 + 32'(k));
            else idle_inputs();
            cycle();
            if (last_accept) k++;
            if (c == 4) begin
                check("t3_full_cnt", q_count, 4);
                check("t3_full_rdy", st_ready, 1'b0);
            end
        end
        check("t3_all_taken", k, 5);
        idle_inputs();

        // 4: load hazard on a queued word.
        mem_req_ready = 1'b0;
        put_store(2'b10, 32'h0000_3000, 32'h5555_AAAA);
        cycle();
        idle_inputs();
        ld_valid = 1'b1;
        ld_addr  = 32'h0000_3002;
        #1;
        check("t4_hit", ld_hazard, 1'b1);
        cycle();
        ld_addr = 32'h0000_3004;
        #1;
        check("t4_miss", ld_hazard, 1'b0);
        cycle();
        idle_inputs();
        mem_req_ready = 1'b1;
        cycle();

        // 5: drain with a toggling memory, then a drain on an empty queue.
        mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put_store(2'b00, 32'h0000_5000 + 32'(i), 32'(i + 1));
            cycle();
        end
        idle_inputs();
        drain_req   = 1'b1;
        done_pulses = 0;
        cycle();
        drain_req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            mem_req_ready = i[0];
            cycle();
        end
        check("t5_one_pulse", done_pulses, 1);
        mem_req_ready = 1'b1;
        drain_req     = 1'b1;
        cycle();
        drain_req = 1'b0;
        check("t5_empty_d1", drain_done, 1'b0);
        cycle();
        check("t5_empty_d2", drain_done, 1'b1);
        cycle();
        check("t5_back_run", st_ready, 1'b1);

        // 6: reset while draining a non-empty queue.
        mem_req_ready = 1'b0;
        put_store(2'b10, 32'h0000_6000, 32'h1);
        cycle();
        put_store(2'b10, 32'h0000_6004, 32'h2);
        cycle();
        idle_inputs();
        drain_req = 1'b1;
        cycle();
        drain_req = 1'b0;
        rst       = 1'b0;
        cycle();
        rst = 1'b1;
        check("t6_cnt", q_count, 0);
        check("t6_valid", mem_req_valid, 1'b0);
        check("t6_ready", st_ready, 1'b1);
        done_pulses = 0;
        repeat (4) cycle();
        check("t6_no_done", done_pulses, 0);

        // Randomized traffic over a small address window so hazards are common.
        for (int c = 0; c < 3000; c++) begin
            st_valid      = ($urandom_range(0, 9) < 6);
            st_sel        = 2'($urandom_range(0, 3));
            st_addr       = 32'h0000_7000 + 32'($urandom_range(0, 15));
            st_data       = $urandom;
            ld_valid      = $urandom_range(0, 1) == 1;
            ld_addr       = 32'h0000_7000 + 32'($urandom_range(0, 19));
            mem_req_ready = ($urandom_range(0, 9) < 5);
            drain_req     = ($urandom_range(0, 24) == 0);
            rst           = ($urandom_range(0, 299) != 0);
            cycle();
        end
        rst = 1'b1;
        idle_inputs();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/store_queue_ctrl.md
Name: store_queue_ctrl

Overview:
- Store buffer and write sequencer between the memory stage and the data memory / MMIO write port.
- Accepts one store per cycle from the pipeline, with the store type already decoded (00 sb, 01 sh, 10 sw, 11 none).
- Builds the byte mask and lane-aligned write data, queues the store, and drains stores in order to memory over a valid/ready handshake.
- Flags loads that hit a still-queued store, and provides a drain (fence) sequence.

Parameters:
- DEPTH, 4, number of queue entries; must be a power of 2, at least 2.
- PTR_W, 2, log2(DEPTH); kept consistent with DEPTH.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low (asserted when 0).
- st_valid  in  1  a store is presented this cycle.
- st_sel  in  2  store type: 00 sb, 01 sh, 10 sw, 11 none.
- st_addr  in  32  byte address of the store.
- st_data  in  32  raw rs2 value; the low byte/half/word is significant.
- st_ready  out  1  queue can accept a store this cycle.
- misalign_err  out  1  one-cycle pulse when a misaligned store is dropped.
- mem_req_valid  out  1  head entry is presented to memory.
- mem_req_ready  in  1  memory accepts the head this cycle.
- mem_addr  out  32  word-aligned address of the head entry ({addr[31:2],2'b00}).
- mem_wdata  out  32  lane-aligned write data of the head entry.
- mem_wmask  out  4  byte enables of the head entry.
- ld_valid  in  1  a load is in the memory stage.
- ld_addr  in  32  load byte address.
- ld_hazard  out  1  load word matches a queued entry; the pipeline must stall the load.
- drain_req  in  1  request to drain the queue (fence, or an MMIO read-after-write).
- drain_done  out  1  one-cycle pulse when a drain completes.
- q_count  out  PTR_W+1  number of occupied entries.

Behaviour:
- Reset (rst==0 at a clock edge):
  - Clears the head/tail pointers and q_count, and invalidates every entry.
  - Sets the FSM to RUN.
  - All outputs are 0 after reset, except st_ready=1.
  - Reset mid-drain discards all queued stores and issues no drain_done.

- Accept condition: a store is accepted when st_valid && st_ready && st_sel!=2'b11 && the store is aligned.
  - st_sel==11 with st_valid=1 is ignored silently (no enqueue, no error).

- Alignment:
  - sh requires addr[0]==0.
  - sw requires addr[1:0]==0.
  - sb is always aligned.
  - A misaligned store is not enqueued, and misalign_err pulses in the next cycle.

- Mask and data, computed at enqueue time:
  - sb: mask = 4'b0001<<addr[1:0]; data = {4{st_data[7:0]}}.
  - sh: mask = addr[1] ? 4'b1100 : 4'b0011; data = {2{st_data[15:0]}}.
  - sw: mask = 4'b1111; data = st_data.

- st_ready = (state==RUN) && (q_count<DEPTH).
  - There is no full-queue bypass: when q_count==DEPTH, st_ready stays 0 even if a dequeue happens in the same cycle.

- Memory handshake:
  - mem_req_valid = (q_count!=0); it is driven from registered queue state.
  - mem_addr, mem_wdata and mem_wmask come from the head entry and stay stable while mem_req_valid && !mem_req_ready.
  - The head is dequeued on mem_req_valid && mem_req_ready.
  - Latency: a store enqueued at edge N is visible on mem_req_valid in the cycle after edge N. The earliest memory accept is edge N+1.
  - A simultaneous enqueue and dequeue leaves q_count unchanged. Pointers wrap modulo DEPTH.
  - Stores leave in strict program order.

- ld_hazard (combinational):
  - ld_hazard = ld_valid && there exists a valid entry e with e.addr[31:2]==ld_addr[31:2].
  - A store being enqueued in the same cycle is not compared (the pipeline orders it after that load).
  - An entry being dequeued in the same cycle still counts as a match.

- FSM states: RUN, DRAIN, DONE.
  - RUN→DRAIN on drain_req.
  - DRAIN: st_ready=0. In DRAIN, when q_count==0 (including after a final dequeue), go to DONE.
  - DONE: drain_done=1 for exactly one cycle, then RUN.
  - drain_req in RUN with an empty queue still passes through DRAIN→DONE, so drain_done appears 2 cycles after the request.
  - drain_req is ignored while in DRAIN or DONE.

Test Plan:
1. Reset, then sb addr=0x1003 data=0x000000AB with mem_req_ready=1 → next cycle mem_req_valid=1, mem_addr=0x1000, mem_wmask=1000, mem_wdata=0xABABABAB; q_count returns to 0.
2. sh addr=0x2002 data=0x1234CAFE, then sw addr=0x2005 → sh produces mask 1100 and wdata 0xCAFECAFE; sw is dropped with misalign_err pulsing once, and q_count never exceeds 1.
3. mem_req_ready=0, then 5 consecutive sw stores → st_ready falls after the 4th and q_count=4. The 5th is held by the pipeline until mem_req_ready=1. Outputs stay stable while stalled, and the drain order matches the issue order.
4. Queue holds sw addr=0x3000; ld_addr=0x3002 with ld_valid=1 → ld_hazard=1. With ld_addr=0x3004 → ld_hazard=0.
5. Three stores queued with mem_req_ready toggling, then drain_req → st_ready=0 until empty; drain_done pulses once, one cycle after q_count reaches 0. drain_req on an empty queue → drain_done 2 cycles later.
6. rst=0 for one edge while 2 entries are queued in DRAIN → q_count=0, mem_req_valid=0, st_ready=1, no drain_done.
